// File: rtl/lab2_proc_muldiv_unit.sv
// lab2_proc_muldiv_unit: iterative shift-add multiplier and restoring divider with val/rdy streams
module lab2_proc_muldiv_unit #(
    parameter int p_nbits      = 32,
    parameter bit p_early_exit = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               istream_val,
    output logic               istream_rdy,
    input  logic [2:0]         istream_fn,
    input  logic [p_nbits-1:0] istream_a,
    input  logic [p_nbits-1:0] istream_b,
    output logic               ostream_val,
    input  logic               ostream_rdy,
    output logic [p_nbits-1:0] ostream_msg
);
    localparam int cw = $clog2(p_nbits) + 1;
    localparam logic [p_nbits-1:0] min_val = {1'b1, {(p_nbits-1){1'b0}}};
    localparam logic [cw-1:0] last_cnt = cw'(p_nbits - 1);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_next;
    logic [2:0]         fn;
    logic [p_nbits-1:0] acc, opa, opb;
    logic               neg;
    logic [cw-1:0]      cnt;
    logic               accept, in_signed, b_zero, ovf, direct;
    logic [p_nbits-1:0] direct_msg, a_mag, b_mag, acc_mul, r_nx, q_nx, result;
    logic [p_nbits:0]   t, diff;
    logic               ge, last;
    assign istream_rdy = state == IDLE;
    assign ostream_val = state == DONE;
    assign accept      = istream_val && istream_rdy;
    // Request decode: trivial cases skip CALC and produce their result immediately
    always_comb begin
        in_signed  = istream_fn == 3'd1 || istream_fn == 3'd3;
        b_zero     = istream_b == '0;
        ovf        = in_signed && istream_a == min_val && istream_b == '1;
        direct     = istream_fn > 3'd4 || b_zero || ovf;
        direct_msg = (istream_fn > 3'd4 || istream_fn == 3'd0) ? '0 :
                     b_zero ? ((istream_fn == 3'd1 || istream_fn == 3'd2) ? '1 : istream_a) :
                     (istream_fn == 3'd1 ? istream_a : '0);
        a_mag      = (in_signed && istream_a[p_nbits-1]) ? -istream_a : istream_a;
        b_mag      = (in_signed && istream_b[p_nbits-1]) ? -istream_b : istream_b;
    end
    // One iteration of shift-add or restoring division, plus final sign fix-up
    always_comb begin
        acc_mul = acc + (opb[0] ? opa : '0);
        t       = {acc, opa[p_nbits-1]};
        diff    = t - {1'b0, opb};
        ge      = !diff[p_nbits];
        r_nx    = ge ? diff[p_nbits-1:0] : t[p_nbits-1:0];
        q_nx    = {opa[p_nbits-2:0], ge};
        last    = (fn == 3'd0 && p_early_exit) ? (opb >> 1) == '0 : cnt == last_cnt;
        result  = fn == 3'd0 ? acc_mul :
                  (fn == 3'd1 || fn == 3'd2) ? (neg ? -q_nx : q_nx) :
                  (neg ? -r_nx : r_nx);
    end
    // Next-state selection
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = accept ? (direct ? DONE : CALC) : IDLE;
            CALC:    state_next = last ? DONE : CALC;
            DONE:    state_next = ostream_rdy ? IDLE : DONE;
            default: state_next = IDLE;
        endcase
    end
    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            fn          <= '0;
            acc         <= '0;
            opa         <= '0;
            opb         <= '0;
            neg         <= 1'b0;
            cnt         <= '0;
            ostream_msg <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                fn  <= istream_fn;
                acc <= '0;
                opa <= istream_fn == 3'd0 ? istream_a : a_mag;
                opb <= istream_fn == 3'd0 ? istream_b : b_mag;
                neg <= istream_fn == 3'd1 ? istream_a[p_nbits-1] ^ istream_b[p_nbits-1] :
                       istream_fn == 3'd3 ? istream_a[p_nbits-1] : 1'b0;
                cnt <= '0;
                if (direct) ostream_msg <= direct_msg;
            end else if (state == CALC) begin
                acc <= fn == 3'd0 ? acc_mul : r_nx;
                opa <= fn == 3'd0 ? opa << 1 : q_nx;
                opb <= fn == 3'd0 ? opb >> 1 : opb;
                cnt <= cnt + 1'b1;
                if (last) ostream_msg <= result;
            end
        end
    end
endmodule

// File: tb/tb_lab2_proc_muldiv_unit.sv
// tb_lab2_proc_muldiv_unit: directed vectors for the mul/div unit, with a second instance without early exit
module tb_lab2_proc_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        istream_val = 1'b0, istream_val2 = 1'b0;
    logic        istream_rdy, istream_rdy2;
    logic [2:0]  istream_fn = '0;
    logic [31:0] istream_a = '0, istream_b = '0;
    logic        ostream_val, ostream_val2;
    logic        ostream_rdy = 1'b1;
    logic [31:0] ostream_msg, ostream_msg2;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    lab2_proc_muldiv_unit dut (
        .clk(clk), .reset(reset),
        .istream_val(istream_val), .istream_rdy(istream_rdy),
        .istream_fn(istream_fn), .istream_a(istream_a), .istream_b(istream_b),
        .ostream_val(ostream_val), .ostream_rdy(ostream_rdy), .ostream_msg(ostream_msg)
    );

    lab2_proc_muldiv_unit #(.p_nbits(32), .p_early_exit(1'b0)) dut2 (
        .clk(clk), .reset(reset),
        .istream_val(istream_val2), .istream_rdy(istream_rdy2),
        .istream_fn(istream_fn), .istream_a(istream_a), .istream_b(istream_b),
        .ostream_val(ostream_val2), .ostream_rdy(1'b1), .ostream_msg(ostream_msg2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request to dut (sel=0) or dut2 (sel=1), then check result and latency
    task automatic run(input string tag, input bit sel, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        check({tag, "_rdy"}, sel ? istream_rdy2 : istream_rdy, 1'b1);
        istream_fn = f;
        istream_a  = a;
        istream_b  = b;
        if (sel) istream_val2 = 1'b1; else istream_val = 1'b1;
        @(posedge clk);
        #1;
        istream_val  = 1'b0;
        istream_val2 = 1'b0;
        lat = 1;
        while (!(sel ? ostream_val2 : ostream_val) && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_msg"}, sel ? ostream_msg2 : ostream_msg, exp);
        check({tag, "_lat"}, lat, exp_lat);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        repeat (3) @(posedge clk);
        #1;
        check("rst_irdy", istream_rdy, 1'b1);
        check("rst_oval", ostream_val, 1'b0);
        check("rst_msg", ostream_msg, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        run("mul_7x6",    0, 3'd0, 32'd7, 32'd6, 32'd42, 4);
        run("mul_m3xmin", 0, 3'd0, 32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 33);
        run("mul2_m3xmin",1, 3'd0, 32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 33);
        run("mul2_7x6",   1, 3'd0, 32'd7, 32'd6, 32'd42, 33);
        run("mul_100sq",  0, 3'd0, 32'd100, 32'd100, 32'd10000, 8);
        run("mul_bone",   0, 3'd0, 32'h1234_5678, 32'd1, 32'h1234_5678, 2);
        run("mul_bzero",  0, 3'd0, 32'd5, 32'd0, 32'd0, 1);
        run("div_m7_2",   0, 3'd1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run("rem_m7_2",   0, 3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run("remu_7_2",   0, 3'd4, 32'd7, 32'd2, 32'd1, 33);
        run("div_7_m2",   0, 3'd1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run("rem_7_m2",   0, 3'd3, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
        run("rem_m100_7", 0, 3'd3, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33);
        run("divu_big",   0, 3'd2, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 33);
        run("divu_5_0",   0, 3'd2, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run("rem_5_0",    0, 3'd3, 32'd5, 32'd0, 32'd5, 1);
        run("div_ovf",    0, 3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run("rem_ovf",    0, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run("fn_rsvd",    0, 3'd6, 32'd9, 32'd9, 32'd0, 1);

        // Back-pressure in DONE while a new request is already waiting
        @(negedge clk);
        ostream_rdy = 1'b0;
        istream_fn  = 3'd0;
        istream_a   = 32'd7;
        istream_b   = 32'd6;
        istream_val = 1'b1;
        lat = 0;
        while (!ostream_val && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("stall_lat", lat, 4);
        istream_a = 32'd3;
        istream_b = 32'd3;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("stall_msg", ostream_msg, 32'd42);
            check("stall_irdy", istream_rdy, 1'b0);
        end
        check("stall_oval", ostream_val, 1'b1);
        @(negedge clk);
        ostream_rdy = 1'b1;
        @(posedge clk);
        #1;
        check("hs_irdy", istream_rdy, 1'b1);
        check("hs_oval", ostream_val, 1'b0);
        @(posedge clk);
        #1;
        istream_val = 1'b0;
        check("next_acc", istream_rdy, 1'b0);
        lat = 1;
        while (!ostream_val && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("next_msg", ostream_msg, 32'd9);
        check("next_lat", lat, 3);
        @(posedge clk);
        #1;

        // Reset in the middle of a division discards it
        @(negedge clk);
        istream_fn  = 3'd1;
        istream_a   = 32'd100;
        istream_b   = 32'd7;
        istream_val = 1'b1;
        @(posedge clk);
        #1;
        istream_val = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_irdy", istream_rdy, 1'b1);
        check("mid_rst_oval", ostream_val, 1'b0);
        check("mid_rst_msg", ostream_msg, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ostream_val) lat++;
        end
        check("no_ghost", lat, 0);
        run("mul_3x3", 0, 3'd0, 32'd3, 32'd3, 32'd9, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
